// File: rtl/priv_1_12_csr_sequencer_pkg.sv
// Types shared by the Zicsr read-modify-write sequencer, its ALU and its pipeline interface.
package priv_1_12_csr_sequencer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [11:0] csr_addr_t;

    typedef enum logic [1:0] {
        PRIV_U    = 2'b00,
        PRIV_S    = 2'b01,
        PRIV_RSVD = 2'b10,
        PRIV_M    = 2'b11
    } priv_level_t;

    // funct3 encodings of the SYSTEM opcode; 000 and 100 are not Zicsr ops
    typedef enum logic [2:0] {
        CSR_ILL0 = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_ILL4 = 3'b100,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_READ,
        SEQ_WRITE,
        SEQ_RESP
    } seq_state_t;

endpackage

// File: rtl/priv_1_12_csr_sequencer_if.sv
// Request/response channel between the execute stage and the CSR sequencer.
interface priv_1_12_csr_sequencer_if;
    import priv_1_12_csr_sequencer_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    csr_addr_t  req_addr;
    word_t      req_rs1_val;
    logic [4:0] req_uimm;

    logic       rsp_valid;
    logic       rsp_ready;
    word_t      rsp_rdata;
    logic       rsp_illegal;

    modport master (
        output req_valid, req_op, req_addr, req_rs1_val, req_uimm, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_rs1_val, req_uimm, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

endinterface

// File: rtl/priv_1_12_csr_alu.sv
// Combinational new-value generator for CSRRW/RS/RC and their immediate forms.
module priv_1_12_csr_alu
    import priv_1_12_csr_sequencer_pkg::*;
(
    input  csr_op_t op,
    input  word_t   old_val,
    input  word_t   operand,
    output word_t   new_val
);

    always_comb begin
        new_val = old_val;
        case (op)
            CSR_RW, CSR_RWI: new_val = operand;
            CSR_RS, CSR_RSI: new_val = old_val | operand;
            CSR_RC, CSR_RCI: new_val = old_val & ~operand;
            default:         new_val = old_val;
        endcase
    end

endmodule

// File: rtl/priv_1_12_csr_sequencer.sv
// Sequences one Zicsr instruction as a read phase then an optional write phase,
// applying privilege and read-only checks before any write reaches the CSR file.
module priv_1_12_csr_sequencer
    import priv_1_12_csr_sequencer_pkg::*;
#(
    parameter bit CHECK_PRIV          = 1'b1,
    parameter bit SUPPRESS_ZERO_WRITE = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    priv_1_12_csr_sequencer_if.slave pipe,
    input  priv_level_t              curr_priv,
    output csr_addr_t                csr_addr,
    output logic                     csr_mod,
    output word_t                    new_csr_val,
    input  word_t                    old_csr_val,
    input  logic                     invalid_csr
);

    seq_state_t state;
    csr_op_t    op_q;
    word_t      operand_q;
    logic       is_zero_q;
    word_t      rdata_q;

    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_illegal;
    word_t      rsp_rdata;

    logic [1:0] priv_lvl;
    logic       reserved_op;
    logic       do_write;
    logic       priv_fail;
    logic       ro_fail;
    logic       illegal;
    word_t      alu_val;

    assign priv_lvl = curr_priv;

    // Evaluated while in READ, where csr_addr and invalid_csr refer to the latched op
    always_comb begin
        reserved_op = (op_q == CSR_ILL0) || (op_q == CSR_ILL4);
        do_write    = (op_q == CSR_RW) || (op_q == CSR_RWI) ||
                      !(SUPPRESS_ZERO_WRITE && is_zero_q);
        priv_fail   = CHECK_PRIV && (csr_addr[9:8] > priv_lvl);
        ro_fail     = CHECK_PRIV && do_write && (csr_addr[11:10] == 2'b11);
        illegal     = reserved_op || invalid_csr || priv_fail || ro_fail;
    end

    // Write data comes from the value captured in READ, not the live CSR read port
    priv_1_12_csr_alu alu (
        .op      (op_q),
        .old_val (rdata_q),
        .operand (operand_q),
        .new_val (alu_val)
    );

    assign new_csr_val      = csr_mod ? alu_val : '0;
    assign pipe.req_ready   = req_ready;
    assign pipe.rsp_valid   = rsp_valid;
    assign pipe.rsp_rdata   = rsp_rdata;
    assign pipe.rsp_illegal = rsp_illegal;

    always_ff @(posedge CLK) begin
        if (state == SEQ_IDLE && pipe.req_valid) begin
            op_q      <= csr_op_t'(pipe.req_op);
            operand_q <= pipe.req_op[2] ? {27'd0, pipe.req_uimm} : pipe.req_rs1_val;
            is_zero_q <= (pipe.req_uimm == 5'd0);
        end
        if (state == SEQ_READ) begin
            rdata_q <= old_csr_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= SEQ_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_illegal <= 1'b0;
            csr_mod     <= 1'b0;
            csr_addr    <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (pipe.req_valid) begin
                        state     <= SEQ_READ;
                        req_ready <= 1'b0;
                        csr_addr  <= pipe.req_addr;
                    end
                end
                SEQ_READ: begin
                    if (do_write && !illegal) begin
                        state   <= SEQ_WRITE;
                        csr_mod <= 1'b1;
                    end else begin
                        state       <= SEQ_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_illegal <= illegal;
                        rsp_rdata   <= illegal ? '0 : old_csr_val;
                    end
                end
                SEQ_WRITE: begin
                    state       <= SEQ_RESP;
                    csr_mod     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_illegal <= 1'b0;
                    rsp_rdata   <= rdata_q;
                end
                SEQ_RESP: begin
                    if (pipe.rsp_ready) begin
                        state       <= SEQ_IDLE;
                        req_ready   <= 1'b1;
                        rsp_valid   <= 1'b0;
                        rsp_illegal <= 1'b0;
                        rsp_rdata   <= '0;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priv_1_12_csr_sequencer.sv
// Scoreboard bench for the CSR sequencer: expected responses are queued as each op is issued.
module tb_priv_1_12_csr_sequencer;
    import priv_1_12_csr_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    priv_level_t curr_priv;
    word_t       old_csr_val;
    logic        invalid_csr;
    csr_addr_t   csr_addr;
    logic        csr_mod;
    word_t       new_csr_val;

    priv_1_12_csr_sequencer_if pipe();

    priv_1_12_csr_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .pipe        (pipe),
        .curr_priv   (curr_priv),
        .csr_addr    (csr_addr),
        .csr_mod     (csr_mod),
        .new_csr_val (new_csr_val),
        .old_csr_val (old_csr_val),
        .invalid_csr (invalid_csr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        word_t     rdata;
        logic      illegal;
        logic      wr;
        word_t     nv;
        csr_addr_t addr;
    } exp_t;

    typedef struct {
        word_t     rdata;
        logic      illegal;
        int        lat;
        int        mods;
        word_t     nv;
        csr_addr_t waddr;
        logic      busy_ready;
        logic      timeout;
        int        acc_cyc;
    } obs_t;

    typedef struct {
        priv_level_t priv;
        logic        inv;
        word_t       old;
        logic [2:0]  op;
        csr_addr_t   addr;
        word_t       rs1;
        logic [4:0]  uimm;
        logic        scr;
        word_t       e_rdata;
        logic        e_ill;
        logic        e_wr;
        word_t       e_new;
    } case_t;

    exp_t      exp_q[$];
    case_t     tbl[15];
    int        errors = 0;
    int        checks = 0;
    int        mod_count = 0;
    int        cyc = 0;
    word_t     last_new = '0;
    csr_addr_t last_addr = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe the write strobe once per cycle, away from the active edge
    always @(negedge CLK) begin
        if (csr_mod === 1'b1) begin
            mod_count = mod_count + 1;
            last_new  = new_csr_val;
            last_addr = csr_addr;
        end
    end

    // Issues one request, waits (bounded) for the response and records what was seen
    task automatic do_op(input logic [2:0] op, input csr_addr_t addr, input word_t rs1,
                         input logic [4:0] uimm, input logic scramble, output obs_t o);
        int m0;
        m0           = mod_count;
        o.rdata      = '0;
        o.illegal    = 1'b0;
        o.nv         = '0;
        o.waddr      = '0;
        o.timeout    = 1'b1;
        pipe.req_op      = op;
        pipe.req_addr    = addr;
        pipe.req_rs1_val = rs1;
        pipe.req_uimm    = uimm;
        pipe.req_valid   = 1'b1;
        @(posedge CLK);
        #1;
        o.acc_cyc      = cyc;
        pipe.req_valid = 1'b0;
        o.busy_ready   = pipe.req_ready;
        o.lat          = 1;
        for (int i = 0; i < 20; i++) begin
            if (pipe.rsp_valid === 1'b1) begin
                o.timeout = 1'b0;
                break;
            end
            @(posedge CLK);
            #1;
            o.lat = o.lat + 1;
            if (scramble && o.lat == 2) old_csr_val = 32'hA5A5_5A5A;
        end
        o.rdata   = pipe.rsp_rdata;
        o.illegal = pipe.rsp_illegal;
        if (!o.timeout) begin
            @(posedge CLK);
            #1;
        end
        o.mods  = mod_count - m0;
        o.nv    = last_new;
        o.waddr = last_addr;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (pipe.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", pipe.req_ready); end
        checks++; if (pipe.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", pipe.rsp_valid); end
        checks++; if (pipe.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", pipe.rsp_rdata); end
        checks++; if (pipe.rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_rsp_illegal got %b want 0", pipe.rsp_illegal); end
        checks++; if (csr_mod !== 1'b0) begin errors++; $display("FAIL reset_csr_mod got %b want 0", csr_mod); end
        checks++; if (csr_addr !== 12'h0) begin errors++; $display("FAIL reset_csr_addr got %h want 0", csr_addr); end
        checks++; if (new_csr_val !== 32'h0) begin errors++; $display("FAIL reset_new_csr_val got %h want 0", new_csr_val); end
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_ops();
        tbl[0]  = '{PRIV_M, 1'b0, 32'h1234_5678, 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5,  1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[1]  = '{PRIV_M, 1'b0, 32'h0000_00F0, 3'b110, 12'h340, 32'hFFFF_FFFF, 5'd0,  1'b0, 32'h0000_00F0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{PRIV_M, 1'b0, 32'h0000_00FF, 3'b111, 12'h340, 32'h0,         5'd5,  1'b0, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00FA};
        tbl[3]  = '{PRIV_M, 1'b0, 32'h0000_0007, 3'b001, 12'hF14, 32'h0000_ABCD, 5'd3,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[4]  = '{PRIV_M, 1'b0, 32'h0000_0007, 3'b010, 12'hF14, 32'h0000_1234, 5'd0,  1'b0, 32'h0000_0007, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{PRIV_U, 1'b0, 32'h0000_1800, 3'b010, 12'h300, 32'h0000_000F, 5'd3,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[6]  = '{PRIV_M, 1'b0, 32'h0000_0042, 3'b100, 12'h340, 32'h1,         5'd1,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[7]  = '{PRIV_M, 1'b1, 32'h0000_0042, 3'b001, 12'h7C0, 32'h1,         5'd1,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[8]  = '{PRIV_M, 1'b0, 32'h1800_0000, 3'b010, 12'h300, 32'h0000_0088, 5'd10, 1'b1, 32'h1800_0000, 1'b0, 1'b1, 32'h1800_0088};
        tbl[9]  = '{PRIV_M, 1'b0, 32'h0000_FFFF, 3'b011, 12'h340, 32'h0000_0F0F, 5'd1,  1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_F0F0};
        tbl[10] = '{PRIV_M, 1'b0, 32'hAAAA_AAAA, 3'b101, 12'h340, 32'h0,         5'd31, 1'b0, 32'hAAAA_AAAA, 1'b0, 1'b1, 32'h0000_001F};
        tbl[11] = '{PRIV_M, 1'b0, 32'h0000_0005, 3'b101, 12'h340, 32'hFFFF_FFFF, 5'd0,  1'b0, 32'h0000_0005, 1'b0, 1'b1, 32'h0};
        tbl[12] = '{PRIV_S, 1'b0, 32'h0000_0011, 3'b001, 12'h140, 32'h0000_0022, 5'd2,  1'b0, 32'h0000_0011, 1'b0, 1'b1, 32'h0000_0022};
        tbl[13] = '{PRIV_M, 1'b0, 32'h0000_0009, 3'b000, 12'h340, 32'h1,         5'd1,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[14] = '{PRIV_U, 1'b0, 32'h0000_0077, 3'b111, 12'hC00, 32'h0,         5'd0,  1'b0, 32'h0000_0077, 1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            obs_t o;
            curr_priv   = tbl[i].priv;
            invalid_csr = tbl[i].inv;
            old_csr_val = tbl[i].old;
            e.rdata   = tbl[i].e_rdata;
            e.illegal = tbl[i].e_ill;
            e.wr      = tbl[i].e_wr;
            e.nv      = tbl[i].e_new;
            e.addr    = tbl[i].addr;
            exp_q.push_back(e);
            do_op(tbl[i].op, tbl[i].addr, tbl[i].rs1, tbl[i].uimm, tbl[i].scr, o);
            invalid_csr = 1'b0;
            e = exp_q.pop_front();
            checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL op%0d_timeout no rsp_valid within 20 cycles", i); end
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL op%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            checks++; if (o.illegal !== e.illegal) begin errors++; $display("FAIL op%0d_illegal got %b want %b", i, o.illegal, e.illegal); end
            checks++; if (o.lat != (e.wr ? 3 : 2)) begin errors++; $display("FAIL op%0d_latency got %0d want %0d", i, o.lat, e.wr ? 3 : 2); end
            checks++; if (o.mods != (e.wr ? 1 : 0)) begin errors++; $display("FAIL op%0d_csr_mod_cycles got %0d want %0d", i, o.mods, e.wr ? 1 : 0); end
            checks++; if (o.busy_ready !== 1'b0) begin errors++; $display("FAIL op%0d_req_ready_busy got %b want 0", i, o.busy_ready); end
            if (e.wr) begin
                checks++; if (o.nv !== e.nv) begin errors++; $display("FAIL op%0d_new_csr_val got %h want %h", i, o.nv, e.nv); end
                checks++; if (o.waddr !== e.addr) begin errors++; $display("FAIL op%0d_csr_addr got %h want %h", i, o.waddr, e.addr); end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        obs_t o;
        int   n;
        int   m0;
        int   hs_cyc;
        curr_priv   = PRIV_M;
        invalid_csr = 1'b0;
        old_csr_val = 32'h0000_1111;
        m0 = mod_count;
        e.rdata = 32'h0000_1111; e.illegal = 1'b0; e.wr = 1'b1; e.nv = 32'h0000_1113; e.addr = 12'h340;
        exp_q.push_back(e);
        pipe.rsp_ready   = 1'b0;
        pipe.req_op      = 3'b010;
        pipe.req_addr    = 12'h340;
        pipe.req_rs1_val = 32'h0000_0002;
        pipe.req_uimm    = 5'd7;
        pipe.req_valid   = 1'b1;
        @(posedge CLK);
        #1;
        pipe.req_valid = 1'b0;
        n = 0;
        while (pipe.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        checks++; if (pipe.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout rsp_valid got %b want 1", pipe.rsp_valid); end
        checks++; if (pipe.rsp_rdata !== e.rdata) begin errors++; $display("FAIL bp_rdata got %h want %h", pipe.rsp_rdata, e.rdata); end
        checks++; if (last_new !== e.nv) begin errors++; $display("FAIL bp_new_csr_val got %h want %h", last_new, e.nv); end
        // A competing request while the response is stalled must be ignored
        pipe.req_op      = 3'b001;
        pipe.req_addr    = 12'h305;
        pipe.req_rs1_val = 32'hFFFF_FFFF;
        pipe.req_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            checks++; if (pipe.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got %b want 1", k, pipe.rsp_valid); end
            checks++; if (pipe.rsp_rdata !== e.rdata) begin errors++; $display("FAIL bp_hold_rdata%0d got %h want %h", k, pipe.rsp_rdata, e.rdata); end
            checks++; if (pipe.rsp_illegal !== 1'b0) begin errors++; $display("FAIL bp_hold_illegal%0d got %b want 0", k, pipe.rsp_illegal); end
            checks++; if (pipe.req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready%0d got %b want 0", k, pipe.req_ready); end
        end
        checks++; if (mod_count - m0 != 1) begin errors++; $display("FAIL bp_mod_count got %0d want 1", mod_count - m0); end
        pipe.req_valid = 1'b0;
        pipe.rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        hs_cyc = cyc;
        checks++; if (pipe.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", pipe.rsp_valid); end
        checks++; if (pipe.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got %b want 1", pipe.req_ready); end
        old_csr_val = 32'h0000_00FF;
        e.rdata = 32'h0000_00FF; e.illegal = 1'b0; e.wr = 1'b1; e.nv = 32'h0000_000F; e.addr = 12'h341;
        exp_q.push_back(e);
        do_op(3'b011, 12'h341, 32'h0000_00F0, 5'd4, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.acc_cyc != hs_cyc + 1) begin errors++; $display("FAIL bp_next_accept got cycle %0d want %0d", o.acc_cyc, hs_cyc + 1); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL bp_next_rdata got %h want %h", o.rdata, e.rdata); end
        checks++; if (o.nv !== e.nv) begin errors++; $display("FAIL bp_next_new got %h want %h", o.nv, e.nv); end
        checks++; if (o.mods != 1) begin errors++; $display("FAIL bp_next_mods got %0d want 1", o.mods); end
        m0 = mod_count;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (pipe.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b want 0", pipe.rsp_valid); end
        checks++; if (mod_count != m0) begin errors++; $display("FAIL bp_idle_mods got %0d want 0", mod_count - m0); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o0;
        obs_t o1;
        obs_t o2;
        curr_priv = PRIV_M;
        old_csr_val = 32'h0000_0010;
        e.rdata = 32'h10; e.illegal = 1'b0; e.wr = 1'b1; e.nv = 32'h1; e.addr = 12'h340;
        exp_q.push_back(e);
        do_op(3'b001, 12'h340, 32'h1, 5'd1, 1'b0, o0);
        old_csr_val = 32'h0000_0020;
        e.rdata = 32'h20; e.illegal = 1'b0; e.wr = 1'b0; e.nv = 32'h0; e.addr = 12'h340;
        exp_q.push_back(e);
        do_op(3'b010, 12'h340, 32'hFFFF_0000, 5'd0, 1'b0, o1);
        old_csr_val = 32'h0000_00FF;
        e.rdata = 32'hFF; e.illegal = 1'b0; e.wr = 1'b1; e.nv = 32'h0F; e.addr = 12'h340;
        exp_q.push_back(e);
        do_op(3'b011, 12'h340, 32'h0000_00F0, 5'd3, 1'b0, o2);
        e = exp_q.pop_front();
        checks++; if (o0.rdata !== e.rdata || o0.nv !== e.nv) begin errors++; $display("FAIL b2b_op0 got %h/%h want %h/%h", o0.rdata, o0.nv, e.rdata, e.nv); end
        e = exp_q.pop_front();
        checks++; if (o1.rdata !== e.rdata || o1.mods != 0) begin errors++; $display("FAIL b2b_op1 got %h mods %0d want %h mods 0", o1.rdata, o1.mods, e.rdata); end
        e = exp_q.pop_front();
        checks++; if (o2.rdata !== e.rdata || o2.nv !== e.nv) begin errors++; $display("FAIL b2b_op2 got %h/%h want %h/%h", o2.rdata, o2.nv, e.rdata, e.nv); end
        checks++; if (o1.acc_cyc - o0.acc_cyc != 4) begin errors++; $display("FAIL b2b_write_spacing got %0d want 4", o1.acc_cyc - o0.acc_cyc); end
        checks++; if (o2.acc_cyc - o1.acc_cyc != 3) begin errors++; $display("FAIL b2b_read_spacing got %0d want 3", o2.acc_cyc - o1.acc_cyc); end
    endtask

    task automatic test_reset_mid_write();
        int m0;
        curr_priv   = PRIV_M;
        old_csr_val = 32'h0000_0055;
        m0 = mod_count;
        pipe.req_op      = 3'b001;
        pipe.req_addr    = 12'h340;
        pipe.req_rs1_val = 32'h0000_0099;
        pipe.req_uimm    = 5'd1;
        pipe.req_valid   = 1'b1;
        @(posedge CLK);
        #1;
        pipe.req_valid = 1'b0;
        @(posedge CLK);
        #1;
        checks++; if (csr_mod !== 1'b1) begin errors++; $display("FAIL rstw_in_write csr_mod got %b want 1", csr_mod); end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (pipe.req_ready !== 1'b1) begin errors++; $display("FAIL rstw_req_ready got %b want 1", pipe.req_ready); end
        checks++; if (pipe.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_rsp_valid got %b want 0", pipe.rsp_valid); end
        checks++; if (csr_mod !== 1'b0) begin errors++; $display("FAIL rstw_csr_mod got %b want 0", csr_mod); end
        checks++; if (csr_addr !== 12'h0) begin errors++; $display("FAIL rstw_csr_addr got %h want 0", csr_addr); end
        checks++; if (new_csr_val !== 32'h0) begin errors++; $display("FAIL rstw_new_csr_val got %h want 0", new_csr_val); end
        checks++; if (pipe.rsp_rdata !== 32'h0 || pipe.rsp_illegal !== 1'b0) begin errors++; $display("FAIL rstw_rsp got %h/%b want 0/0", pipe.rsp_rdata, pipe.rsp_illegal); end
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        checks++; if (mod_count - m0 != 1) begin errors++; $display("FAIL rstw_mod_count got %0d want 1", mod_count - m0); end
        checks++; if (pipe.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_after_valid got %b want 0", pipe.rsp_valid); end
    endtask

    initial begin
        RST              = 1'b1;
        pipe.req_valid   = 1'b0;
        pipe.req_op      = 3'b000;
        pipe.req_addr    = '0;
        pipe.req_rs1_val = '0;
        pipe.req_uimm    = '0;
        pipe.rsp_ready   = 1'b1;
        curr_priv        = PRIV_M;
        invalid_csr      = 1'b0;
        old_csr_val      = '0;
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priv_1_12_csr_sequencer.md
Name: priv_1_12_csr_sequencer

Overview:
- Upstream neighbour of the v1.12 privilege CSR file. Accepts one Zicsr instruction at a time from the execute stage.
- Performs the atomic read-modify-write as a read phase then a write phase, driving the CSR file's csr_addr/csr_mod/new_csr_val and consuming old_csr_val/invalid_csr.
- Performs privilege and read-only checks, then returns the old value (rd data) or an illegal-instruction flag to the pipeline over a valid/ready response channel.

Parameters:
- CHECK_PRIV, 1, when 1 enforce addr[9:8] <= curr_priv and the addr[11:10]==2'b11 write rule; when 0 only invalid_csr and bad funct3 flag illegal.
- SUPPRESS_ZERO_WRITE, 1, when 1 set/clear ops with rs1/uimm field zero perform no write phase.

Ports:
- CLK  input  1  core clock
- RST  input  1  synchronous active-high reset
- req_valid  input  1  CSR instruction presented
- req_ready  output  1  sequencer can accept (high only in IDLE)
- req_op  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  input  12  CSR address
- req_rs1_val  input  32  rs1 operand
- req_uimm  input  5  zimm field (also rs1 index for the zero test)
- curr_priv  input  2  current privilege level (priv_level_t)
- csr_addr  output  12  to CSR file
- csr_mod  output  1  write strobe to CSR file
- new_csr_val  output  32  write data to CSR file
- old_csr_val  input  32  read data from CSR file (combinational on csr_addr)
- invalid_csr  input  1  CSR file reports nonexistent address
- rsp_valid  output  1  result available
- rsp_ready  input  1  pipeline consumes result
- rsp_rdata  output  32  old CSR value for rd
- rsp_illegal  output  1  raise illegal-instruction exception

Behaviour:
- Clock CLK; reset RST is synchronous, active-high.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, csr_mod=0, csr_addr=0, new_csr_val=0. Reset mid-operation abandons the op; no csr_mod pulse is issued after reset is sampled.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid&&req_ready, latch op/addr/operand (operand = rs1_val for RW/RS/RC, zero-extended uimm for *I forms) and the is_zero flag (uimm==0), then go to READ.
- READ (1 cycle): csr_addr=latched addr, csr_mod=0. Register old_csr_val into rdata_q.
- READ illegal condition, computed in READ: funct3 000 or 100; or invalid_csr; or (CHECK_PRIV and addr[9:8] > curr_priv); or (CHECK_PRIV and do_write and addr[11:10]==2'b11).
- do_write: RW/RWI always; RS/RC/RSI/RCI unless (SUPPRESS_ZERO_WRITE and is_zero).
- READ transitions: WRITE if do_write and not illegal; otherwise RESP.
- WRITE (1 cycle): csr_mod=1, csr_addr held, new_csr_val = operand (RW), rdata_q|operand (RS), rdata_q&~operand (RC). The value is computed from the registered rdata_q, never from the live old_csr_val. Next state: RESP.
- RESP: rsp_valid=1, rsp_rdata=rdata_q, rsp_illegal per latched flag. Hold all outputs stable until rsp_ready; on handshake go to IDLE.
- Latency from the accept edge: write op rsp_valid at cycle 3; no-write or illegal op at cycle 2. Back-to-back throughput is one op per 3 or 4 cycles.
- req_ready=0 outside IDLE; req_valid during a busy state is ignored (not latched).
- csr_mod is asserted in WRITE only, for exactly one cycle per op; it is never asserted for an illegal op.
- When illegal, rsp_rdata=0.

Decomposition:
- Add csr_op_t (funct3 enum) and the sequencer state enum to machine_mode_types_1_12_pkg; reuse word_t, priv_level_t and the CSR address type from the existing packages.
- A combinational sub-module priv_1_12_csr_alu (op, old, operand -> new value) is natural; the checker logic stays inline.

Test Plan:
- RW: addr 0x340, rs1 0xDEADBEEF, CSR holds 0x12345678 -> one csr_mod pulse with new 0xDEADBEEF; rsp at cycle 3 with rdata 0x12345678, illegal 0.
- RSI uimm 0 (SUPPRESS_ZERO_WRITE=1) -> no csr_mod; rsp at cycle 2 with old value. RCI uimm 0x5 on old 0xFF -> new 0xFA.
- RW to read-only 0xF14 (mhartid) from M-mode -> no csr_mod; rsp_illegal=1, rdata 0. RS with rs1=x0 to 0xF14 -> legal read, no write.
- curr_priv=U, CSRRS to 0x300 -> rsp_illegal=1, no csr_mod. funct3 100 -> illegal. invalid_csr=1 -> illegal.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, a second req_valid is ignored; release -> IDLE, next request accepted the cycle after.
- Assert RST during WRITE -> state IDLE, all outputs at reset values on the next edge, no further csr_mod.
